// File: rtl/pipe_datapath_pkg.sv
// datapath_pkg: shared ALU op encoding and default widths for pipe_datapath
package datapath_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADD_WIDTH_DEF = 5;
  localparam int SHAMT_W = $clog2(DATA_WIDTH_DEF);
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6,
    ALU_SLL  = 3'd7
  } alu_op_e;
endpackage

// File: rtl/pipe_datapath_if.sv
// pipe_datapath_if: instruction handshake and result bus between decode and pipe_datapath
interface pipe_datapath_if import datapath_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADD_WIDTH = ADD_WIDTH_DEF
);
  logic in_valid;
  logic in_ready;
  logic [ADD_WIDTH-1:0] AD1;
  logic [ADD_WIDTH-1:0] AD2;
  logic [ADD_WIDTH-1:0] AD3;
  logic WE3;
  logic ALUsrc;
  logic [2:0] ALUctrl;
  logic [DATA_WIDTH-1:0] Immop;
  logic out_valid;
  logic [DATA_WIDTH-1:0] ALUout;
  logic EQ;
  modport master (
    output in_valid, AD1, AD2, AD3, WE3, ALUsrc, ALUctrl, Immop,
    input in_ready, out_valid, ALUout, EQ
  );
  modport slave (
    input in_valid, AD1, AD2, AD3, WE3, ALUsrc, ALUctrl, Immop,
    output in_ready, out_valid, ALUout, EQ
  );
endinterface

// File: rtl/pipe_datapath_alu.sv
// alu_n: combinational eight-op ALU with operand equality flag
module alu_n import datapath_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  alu_op_e               op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq
);
  localparam int SW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] slt, sltu;
  assign slt = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
  assign sltu = {{(DATA_WIDTH-1){1'b0}}, op1 < op2};
  assign eq = op1 == op2;
  always_comb
    result = op == ALU_ADD ? op1 + op2 :
             op == ALU_SUB ? op1 - op2 :
             op == ALU_AND ? op1 & op2 :
             op == ALU_OR  ? op1 | op2 :
             op == ALU_XOR ? op1 ^ op2 :
             op == ALU_SLT ? slt :
             op == ALU_SLTU ? sltu : op1 << op2[SW-1:0];
endmodule

// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage EX/WB regfile+ALU pipeline; DATAPATH_FWD_EN selects WB bypass over interlock
module pipe_datapath import datapath_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADD_WIDTH = ADD_WIDTH_DEF,
  parameter int A0_ADDR = 10,
  parameter int A1_ADDR = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_datapath_if.slave        bus,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] a1
);
  localparam logic [ADD_WIDTH-1:0] A0_IDX = A0_ADDR[ADD_WIDTH-1:0];
  localparam logic [ADD_WIDTH-1:0] A1_IDX = A1_ADDR[ADD_WIDTH-1:0];
  logic [DATA_WIDTH-1:0] rf [2**ADD_WIDTH];
  logic [DATA_WIDTH-1:0] op1, op2, rd2, res, alu_q;
  logic [ADD_WIDTH-1:0] wb_rd;
  logic wb_we, v_q, eq, eq_q, wb_hit, haz1, haz2, accept;
  assign wb_hit = v_q && wb_we && wb_rd != '0;
  assign haz1 = wb_hit && bus.AD1 == wb_rd;
  assign haz2 = wb_hit && !bus.ALUsrc && bus.AD2 == wb_rd;
`ifdef DATAPATH_FWD_EN
  assign op1 = haz1 ? alu_q : rf[bus.AD1];
  assign rd2 = haz2 ? alu_q : rf[bus.AD2];
  assign bus.in_ready = 1'b1;
`else
  assign op1 = rf[bus.AD1];
  assign rd2 = rf[bus.AD2];
  assign bus.in_ready = !(haz1 || haz2);
`endif
  assign op2 = bus.ALUsrc ? bus.Immop : rd2;
  assign accept = bus.in_valid && bus.in_ready;
  alu_n #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op1(op1),
    .op2(op2),
    .op(alu_op_e'(bus.ALUctrl)),
    .result(res),
    .eq(eq)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= 1'b0;
      alu_q <= '0;
      eq_q <= 1'b0;
      wb_rd <= '0;
      wb_we <= 1'b0;
    end else begin
      v_q <= accept;
      if (accept) begin
        alu_q <= res;
        eq_q <= eq;
        wb_rd <= bus.AD3;
        wb_we <= bus.WE3;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**ADD_WIDTH; i++) rf[i] <= '0;
    else if (wb_hit)
      rf[wb_rd] <= alu_q;
  assign bus.out_valid = v_q;
  assign bus.ALUout = alu_q;
  assign bus.EQ = eq_q;
  assign a0 = rf[A0_IDX];
  assign a1 = rf[A1_IDX];
endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: scoreboard bench for pipe_datapath covering reset, ops, hazards, x0 and mid-flight reset
module tb_pipe_datapath;
  import datapath_pkg::*;
  typedef struct packed {logic [31:0] alu; logic eq;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a0, a1;
  logic [31:0] m_rf [32];
  exp_t sb[$];
  exp_t e;
  int passed = 0;
  int total = 0;
  pipe_datapath_if bus ();
  pipe_datapath dut (.clk(clk), .rst_n(rst_n), .bus(bus), .a0(a0), .a1(a1));
  always #5 clk = ~clk;
  function automatic logic [31:0] mdl(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return a << b[4:0];
    endcase
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    sb.delete();
  endtask
  task automatic issue(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic we, input logic src, input logic [31:0] imm, output int stalls);
    logic [31:0] o1, o2, r;
    o1 = m_rf[s1];
    o2 = src ? imm : m_rf[s2];
    r = mdl(op, o1, o2);
    sb.push_back('{alu: r, eq: o1 == o2});
    if (we && d != 0) m_rf[d] = r;
    bus.AD1 = s1; bus.AD2 = s2; bus.AD3 = d; bus.WE3 = we;
    bus.ALUsrc = src; bus.ALUctrl = op; bus.Immop = imm; bus.in_valid = 1'b1;
    #1;
    stalls = 0;
    while (!bus.in_ready && stalls < 4) begin
      @(posedge clk); #1;
      stalls++;
    end
    @(posedge clk); #1;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.ALUout !== 32'd0) $display("FAIL reset_aluout: got %h want 0", bus.ALUout); else passed++;
    total++; if (bus.EQ !== 1'b0) $display("FAIL reset_eq: got %b want 0", bus.EQ); else passed++;
    total++; if (a0 !== 32'd0 || a1 !== 32'd0) $display("FAIL reset_a0a1: got %h/%h want 0/0", a0, a1); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    idle();
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
  endtask
  task automatic test_addi();
    int st;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5, st);
    e = sb.pop_front();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL addi_out_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.ALUout !== e.alu || e.alu !== 32'd5) $display("FAIL addi_aluout: got %h want %h", bus.ALUout, e.alu); else passed++;
    idle();
    issue(ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0, st);
    e = sb.pop_front();
    total++; if (bus.ALUout !== 32'd5) $display("FAIL addi_readback_x1: got %h want 5", bus.ALUout); else passed++;
    idle();
  endtask
  task automatic test_back_to_back();
    int st, want;
`ifdef DATAPATH_FWD_EN
    want = 0;
`else
    want = 1;
`endif
    issue(ALU_ADD, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'd7, st);
    e = sb.pop_front();
    total++; if (bus.ALUout !== e.alu) $display("FAIL b2b_first: got %h want %h", bus.ALUout, e.alu); else passed++;
    issue(ALU_ADD, 5'd10, 5'd10, 5'd10, 1'b1, 1'b0, 32'd0, st);
    e = sb.pop_front();
    total++; if (st !== want) $display("FAIL b2b_stalls: got %0d want %0d", st, want); else passed++;
    total++; if (bus.ALUout !== e.alu || e.alu !== 32'd14) $display("FAIL b2b_result: got %h want %h", bus.ALUout, e.alu); else passed++;
    idle();
    total++; if (a0 !== 32'd14) $display("FAIL b2b_a0: got %h want 0000000e", a0); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bubble_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.ALUout !== 32'd14) $display("FAIL bubble_hold: got %h want 0000000e", bus.ALUout); else passed++;
  endtask
  task automatic test_ops();
    int st;
    logic [31:0] want [4] = '{32'd1, 32'd0, 32'd2, 32'hFFFF_FFF0};
    logic [2:0] ops [4] = '{ALU_SLT, ALU_SLTU, ALU_SUB, ALU_SLL};
    logic [4:0] s1s [4] = '{5'd1, 5'd1, 5'd2, 5'd1};
    logic [4:0] s2s [4] = '{5'd2, 5'd2, 5'd1, 5'd0};
    logic srcs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    issue(ALU_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, st); void'(sb.pop_front());
    issue(ALU_ADD, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'd1, st); void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], s1s[i], s2s[i], 5'd3, 1'b1, srcs[i], 32'd36, st);
      e = sb.pop_front();
      total++; if (bus.ALUout !== want[i] || e.alu !== want[i]) $display("FAIL ops_%0d: got %h want %h", i, bus.ALUout, want[i]); else passed++;
    end
    for (int i = 2; i <= 4; i++) begin
      issue(3'(i), 5'd1, 5'd3, 5'd4, 1'b1, 1'b0, 32'd0, st);
      e = sb.pop_front();
      total++; if (bus.ALUout !== e.alu) $display("FAIL logic_op_%0d: got %h want %h", i, bus.ALUout, e.alu); else passed++;
    end
    issue(ALU_ADD, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 32'd9, st); void'(sb.pop_front());
    issue(ALU_XOR, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 32'd9, st);
    e = sb.pop_front();
    total++; if (bus.EQ !== e.eq || e.eq !== 1'b1) $display("FAIL eq_equal: got %b want %b", bus.EQ, e.eq); else passed++;
    issue(ALU_ADD, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 32'd8, st);
    e = sb.pop_front();
    total++; if (bus.EQ !== e.eq || e.eq !== 1'b0) $display("FAIL eq_differ: got %b want %b", bus.EQ, e.eq); else passed++;
    idle();
  endtask
  task automatic test_x0();
    int st;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd3, st);
    e = sb.pop_front();
    total++; if (bus.ALUout !== e.alu) $display("FAIL x0_write_result: got %h want %h", bus.ALUout, e.alu); else passed++;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'd0, st);
    e = sb.pop_front();
    total++; if (st !== 0) $display("FAIL x0_no_stall: got %0d want 0", st); else passed++;
    total++; if (bus.ALUout !== 32'd0 || e.alu !== 32'd0) $display("FAIL x0_read: got %h want 0", bus.ALUout); else passed++;
    idle();
  endtask
  task automatic test_reset_mid();
    int st;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'h55, st);
    e = sb.pop_front();
    total++; if (bus.ALUout !== 32'h55) $display("FAIL mid_accept: got %h want 00000055", bus.ALUout); else passed++;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); else passed++;
    @(posedge clk); #1;
    total++; if (a1 !== 32'd0) $display("FAIL mid_a1_discard: got %h want 0", a1); else passed++;
    rst_n = 1'b1;
    clear_model();
    idle();
    total++; if (a1 !== 32'd0 || a0 !== 32'd0) $display("FAIL mid_regs_clear: got %h/%h want 0/0", a0, a1); else passed++;
    issue(ALU_OR, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0, 32'd0, st);
    e = sb.pop_front();
    total++; if (bus.ALUout !== 32'd0 || e.alu !== 32'd0) $display("FAIL mid_rf_cleared: got %h want 0", bus.ALUout); else passed++;
    idle();
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.AD1 = '0; bus.AD2 = '0; bus.AD3 = '0;
    bus.WE3 = 1'b0; bus.ALUsrc = 1'b0; bus.ALUctrl = '0; bus.Immop = '0;
    clear_model();
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_back_to_back();
    test_ops();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
